// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell is time-shared across all
// bit positions, LSB first, one bit per clock, with the carry held in a flop.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for in_start; operands captured on the accepting edge
// RUN     | one operand bit pair added per edge, sum shifted in at the MSB
// DONE    | result registers freshly loaded; out_done high for this cycle

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  // Counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH must be within 2..32");
    end
  endgenerate

  // The only adder cell in the block: current LSBs plus the running carry.
  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // The counter runs down from WIDTH-1; zero marks the MSB pass.
  assign accept   = (state_q == ST_IDLE) && in_start;
  assign last_bit = (state_q == ST_RUN) && (cnt_q == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start requests outside IDLE are dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand shift registers, carry flop and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr    <= '0;
      b_sr    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sr    <= in_a;
      b_sr    <= in_b;
      carry_q <= in_cin;
      cnt_q   <= CNT_LOAD;
    end else if (state_q == ST_RUN) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      carry_q <= fa_c;
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  // Sum assembly: each new bit enters at the MSB so the LSB lands at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_sr <= '0;
    end else if (state_q == ST_RUN) begin
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
    end
  end

  // Result registers change only on the final bit and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (last_bit) begin
      out_sum  <= {fa_s, sum_sr[WIDTH-1:1]};
      out_cout <= fa_c;
    end
  end

  // Status outputs are pure state decodes.
  always_comb begin
    out_busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    out_done = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit and a 16-bit instance, a timing model
// that pushes expected results at each accepted start, and a monitor that pops
// and compares on every done pulse.

module tb_serial_adder_ctrl;

  localparam int W8  = 8;
  localparam int W16 = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tb_end = 1'b0;

  logic           s8_start = 1'b0;
  logic [W8-1:0]  s8_a = '0;
  logic [W8-1:0]  s8_b = '0;
  logic           s8_cin = 1'b0;
  logic           busy8, done8, cout8;
  logic [W8-1:0]  sum8;
  logic [W8:0]    exp8 = '0;

  logic           s16_start = 1'b0;
  logic [W16-1:0] s16_a = '0;
  logic [W16-1:0] s16_b = '0;
  logic           s16_cin = 1'b0;
  logic           busy16, done16, cout16;
  logic [W16-1:0] sum16;
  logic [W16:0]   exp16 = '0;

  logic [W8:0]  q8_res[$];
  int           q8_cyc[$];
  logic [W16:0] q16_res[$];
  int           q16_cyc[$];

  int m8_cnt = 0;
  int m16_cnt = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [W8:0]  last8 = '0;
  logic [W16:0] last16 = '0;

  serial_adder_ctrl #(.WIDTH(W8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .in_start (s8_start),
    .in_a     (s8_a),
    .in_b     (s8_b),
    .in_cin   (s8_cin),
    .out_busy (busy8),
    .out_done (done8),
    .out_sum  (sum8),
    .out_cout (cout8)
  );

  serial_adder_ctrl #(.WIDTH(W16)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .in_start (s16_start),
    .in_a     (s16_a),
    .in_b     (s16_b),
    .in_cin   (s16_cin),
    .out_busy (busy16),
    .out_done (done16),
    .out_sum  (sum16),
    .out_cout (cout16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timing model: a start seen while idle is accepted and the expected result
  // queued; the block then stays busy for WIDTH+1 cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m8_cnt  <= 0;
      m16_cnt <= 0;
    end else begin
      if (m8_cnt == 0) begin
        if (s8_start) begin
          q8_res.push_back(exp8);
          q8_cyc.push_back(cyc + 1);
          m8_cnt <= W8 + 1;
        end
      end else begin
        m8_cnt <= m8_cnt - 1;
      end
      if (m16_cnt == 0) begin
        if (s16_start) begin
          q16_res.push_back(exp16);
          q16_cyc.push_back(cyc + 1);
          m16_cnt <= W16 + 1;
        end
      end else begin
        m16_cnt <= m16_cnt - 1;
      end
      cyc <= cyc + 1;
    end
  end

  // Monitor: all comparisons and the summary live here.
  always begin
    @(negedge clk or posedge reset or posedge tb_end);
    #1;
    if (tb_end) begin
      chk("q8_drained", q8_res.size(), 0);
      chk("q16_drained", q16_res.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (reset) begin
      q8_res.delete();
      q8_cyc.delete();
      q16_res.delete();
      q16_cyc.delete();
      last8  = '0;
      last16 = '0;
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_res8", {cout8, sum8}, 0);
      chk("rst_busy16", busy16, 0);
      chk("rst_done16", done16, 0);
      chk("rst_res16", {cout16, sum16}, 0);
    end else begin
      chk("busy8", busy8, (m8_cnt != 0));
      chk("done8", done8, (m8_cnt == 1));
      if (done8) begin
        chk("done8_expected", (q8_res.size() != 0), 1);
        if (q8_res.size() != 0) begin
          logic [W8:0] r;
          int          acc;
          r   = q8_res.pop_front();
          acc = q8_cyc.pop_front();
          chk("res8", {cout8, sum8}, r);
          chk("lat8", cyc - acc, W8);
          last8 = r;
        end
      end else begin
        chk("hold8", {cout8, sum8}, last8);
      end
      chk("busy16", busy16, (m16_cnt != 0));
      chk("done16", done16, (m16_cnt == 1));
      if (done16) begin
        chk("done16_expected", (q16_res.size() != 0), 1);
        if (q16_res.size() != 0) begin
          logic [W16:0] r;
          int           acc;
          r   = q16_res.pop_front();
          acc = q16_cyc.pop_front();
          chk("res16", {cout16, sum16}, r);
          chk("lat16", cyc - acc, W16);
          last16 = r;
        end
      end else begin
        chk("hold16", {cout16, sum16}, last16);
      end
    end
  end

  // Driver tasks: called at a negedge, return at a negedge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [8:0] e);
    while (m8_cnt != 0) @(negedge clk);
    s8_a = a;
    s8_b = b;
    s8_cin = cin;
    exp8 = e;
    s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [16:0] e);
    while (m16_cnt != 0) @(negedge clk);
    s16_a = a;
    s16_b = b;
    s16_cin = cin;
    exp16 = e;
    s16_start = 1'b1;
    @(negedge clk);
    s16_start = 1'b0;
  endtask

  task automatic idle_all();
    while (m8_cnt != 0 || m16_cnt != 0) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    op8(8'hFF, 8'h01, 1'b0, 9'h100);
    idle_all();

    op8(8'h5A, 8'hA5, 1'b1, 9'h100);
    op8(8'h12, 8'h34, 1'b0, 9'h046);
    idle_all();

    // Start request and operand changes mid-run must be ignored.
    op8(8'h0F, 8'h01, 1'b0, 9'h010);
    repeat (2) @(negedge clk);
    s8_start = 1'b1;
    s8_a = 8'hFF;
    s8_b = 8'hFF;
    @(negedge clk);
    s8_start = 1'b0;
    idle_all();

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    while (m8_cnt != 0) @(negedge clk);
    s8_a = 8'h80;
    s8_b = 8'h80;
    s8_cin = 1'b0;
    exp8 = 9'h100;
    s8_start = 1'b1;
    repeat (40) @(negedge clk);
    s8_start = 1'b0;
    idle_all();

    // Asynchronous reset between edges on RUN cycle 4 discards the operation.
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op8(8'h03, 8'h04, 1'b0, 9'h007);
    idle_all();

    op16(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    op16(16'h1234, 16'h4321, 1'b1, 17'h05556);
    idle_all();

    fork
      begin
        for (int i = 0; i < 500; i++) begin
          logic [7:0] a;
          logic [7:0] b;
          logic       c;
          a = 8'($urandom);
          b = 8'($urandom);
          c = 1'($urandom);
          op8(a, b, c, {1'b0, a} + {1'b0, b} + {8'd0, c});
        end
      end
      begin
        for (int j = 0; j < 500; j++) begin
          logic [15:0] a;
          logic [15:0] b;
          logic        c;
          a = 16'($urandom);
          b = 16'($urandom);
          c = 1'($urandom);
          op16(a, b, c, {1'b0, a} + {1'b0, b} + {16'd0, c});
        end
      end
    join
    idle_all();

    tb_end = 1'b1;
    #20;
    $display("FAIL summary_not_reached: monitor did not finish");
    $fatal(1);
  end

endmodule
